// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Circular byte FIFO that launches one UART frame at a time and
//            tracks the transmitter's busy handshake. The optional flush port
//            is enabled by defining UART_TX_FEEDER_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef UART_TX_FEEDER_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  wr_en,
  input  logic [DATA_SIZE-1:0]  wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_SIZE-1:0]  tx_data
);

  localparam int                    c_DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   c_FULL_COUNT = (ADDR_WIDTH+1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE    = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  logic [DATA_SIZE-1:0]  r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  state_t                r_state;
  logic                  r_tx_start;
  logic [DATA_SIZE-1:0]  r_tx_data;

  state_t                w_next_state;
  logic                  w_tx_start_nxt;
  logic [DATA_SIZE-1:0]  w_tx_data_nxt;
  logic                  w_launch;
  logic                  w_flush;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;

`ifdef UART_TX_FEEDER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full   = (r_count == c_FULL_COUNT);
  assign w_empty  = (r_count == '0);
  // Flush swallows any same-cycle write; full always rejects, even alongside a pop.
  assign w_wr_acc = wr_en & ~w_full & ~w_flush;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
        if (w_launch) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
        case ({w_wr_acc, w_launch})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_launch       = 1'b0;
    case (r_state)
      IDLE: begin
        // A flush blocks the pop, so it must also block the launch.
        if (!w_empty && !tx_busy && !w_flush) begin
          w_launch       = 1'b1;
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = r_mem[r_rd_ptr];
          w_next_state   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_next_state = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Self-checking bench for uart_tx_feeder against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
`ifdef UART_TX_FEEDER_FLUSH_EN
  logic       flush;
`endif

  uart_tx_feeder #(.DATA_SIZE(8), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef UART_TX_FEEDER_FLUSH_EN
    .flush    (flush),
`endif
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];
  bit         ovf_exp;
  logic [7:0] last_data;
  bit         tx_auto;
  bit         xm_active;
  int         xm_delay;
  int         xm_len;
  bit         last_started;
  bit         last_accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model and compare.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
    int         pre;
    logic [7:0] e;
    rst     = r ? 1'b0 : 1'b1;
    wr_en   = w;
    wr_data = d;
`ifdef UART_TX_FEEDER_FLUSH_EN
    flush   = f;
`endif
    pre           = q.size();
    last_started  = 1'b0;
    last_accepted = 1'b0;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      ovf_exp   = 1'b0;
      last_data = 8'h00;
      xm_active = 1'b0;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
    end else begin
      if (tx_start) begin
        last_started = 1'b1;
        chk("start_outside_frame", xm_active, 0);
        chk("start_queue_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("tx_data_launch", tx_data, e);
          last_data = e;
        end
      end else begin
        chk("tx_data_hold", tx_data, last_data);
      end
      if (f) begin
        chk("flush_no_start", tx_start, 0);
        q.delete();
      end else if (w && pre < DEPTH) begin
        q.push_back(d);
        last_accepted = 1'b1;
      end
      if (w && pre == DEPTH) ovf_exp = 1'b1;
    end
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, ovf_exp);
    if (tx_auto) begin
      if (tx_start && !r) begin
        xm_active = 1'b1;
        xm_delay  = $urandom_range(0, 2);
        xm_len    = $urandom_range(1, 4);
      end
      if (xm_active) begin
        if (xm_delay > 0) begin
          tx_busy = 1'b0;
          xm_delay--;
        end else if (xm_len > 0) begin
          tx_busy = 1'b1;
          xm_len--;
        end else begin
          tx_busy   = 1'b0;
          xm_active = 1'b0;
        end
      end else begin
        tx_busy = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || xm_active) && n < 400) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    chk("drain_complete", q.size(), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] pre_cnt;
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
`ifdef UART_TX_FEEDER_FLUSH_EN
    flush = 1'b0;
`endif
    ovf_exp = 1'b0; last_data = 8'h00; tx_auto = 1'b0; xm_active = 1'b0;
    xm_delay = 0; xm_len = 0;

    // Reset and idle.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_tx_start", tx_start, 0);

    // Single byte launch latency and one-cycle start pulse.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_edge_n_start", tx_start, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_edge_n1_start", tx_start, 1);
    chk("lat_edge_n1_data", tx_data, 8'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lat_pulse_width", tx_start, 0);
    tx_busy = 1'b1;
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    tx_busy = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill while busy, overflow, then drain in order.
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", full, 1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_count_16", count, 16);
    chk("ovf_sticky", overflow, 1);
    tx_auto = 1'b1;
    tx_busy = 1'b0;
    drain();

    // Random writes against a draining transmitter; pointers wrap repeatedly.
    for (int i = 0; i < 160; i++) begin
      pre_cnt = count;
      step($urandom_range(0, 9) < 7, 8'($urandom), 1'b0, 1'b0);
      if (last_started && last_accepted) chk("coincide_count", count, pre_cnt);
    end
    drain();

    // Reset while a frame is in WAIT_DONE with 5 bytes queued.
    tx_auto = 1'b0;
    tx_busy = 1'b0;
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_launch", tx_start, 1);
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("pre_rst_count", count, 5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_count", count, 0);
    for (int i = 0; i < 10; i++) begin
      tx_busy = i[0];
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef UART_TX_FEEDER_FLUSH_EN
    // Flush with a coincident write while a frame is in flight.
    step(1'b1, 8'h50, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_pre_launch", tx_start, 1);
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_next_data", tx_data, 8'h77);
    tx_busy = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
